// File: rtl/vec_wb_queue.sv
// Vector writeback queue: per-stream FIFOs for ALU and load results feeding the
// two register-file write ports, with write-after-write ordering on same-rd heads.
module vec_wb_queue #(
    parameter int unsigned XLEN_VEC    = 128,
    parameter int unsigned RFIDX_WIDTH = 5,
    parameter int unsigned DEPTH       = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   alu_valid,
    output logic                   alu_ready,
    input  logic [RFIDX_WIDTH-1:0] alu_rd,
    input  logic [XLEN_VEC-1:0]    alu_data,
    input  logic                   lsu_valid,
    output logic                   lsu_ready,
    input  logic [RFIDX_WIDTH-1:0] lsu_rd,
    input  logic [XLEN_VEC-1:0]    lsu_data,
    output logic [1:0]             vwe,
    output logic [RFIDX_WIDTH-1:0] va5,
    output logic [RFIDX_WIDTH-1:0] va6,
    output logic [XLEN_VEC-1:0]    vwd1,
    output logic [XLEN_VEC-1:0]    vwd2,
    output logic                   idle
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PW = AW + 1;
    localparam int unsigned SW = 4;
    localparam logic [PW-1:0] FULL_DIFF = {1'b1, {AW{1'b0}}};

    // FIFO storage: destination, data and sequence stamp per entry
    logic [RFIDX_WIDTH-1:0] alu_rd_mem  [DEPTH];
    logic [XLEN_VEC-1:0]    alu_dat_mem [DEPTH];
    logic [SW-1:0]          alu_seq_mem [DEPTH];
    logic [RFIDX_WIDTH-1:0] lsu_rd_mem  [DEPTH];
    logic [XLEN_VEC-1:0]    lsu_dat_mem [DEPTH];
    logic [SW-1:0]          lsu_seq_mem [DEPTH];

    logic [PW-1:0]          alu_wp_q, alu_wp_d, alu_rp_q, alu_rp_d;
    logic [PW-1:0]          lsu_wp_q, lsu_wp_d, lsu_rp_q, lsu_rp_d;
    logic [SW-1:0]          seq_q, seq_d;
    logic [1:0]             vwe_q, vwe_d;
    logic [RFIDX_WIDTH-1:0] va5_q, va5_d, va6_q, va6_d;
    logic [XLEN_VEC-1:0]    vwd1_q, vwd1_d, vwd2_q, vwd2_d;

    logic                   alu_empty, alu_full, lsu_empty, lsu_full;
    logic                   alu_push, lsu_push, alu_pop, lsu_pop;
    logic [SW-1:0]          lsu_stamp;
    logic [RFIDX_WIDTH-1:0] alu_h_rd, lsu_h_rd;
    logic [XLEN_VEC-1:0]    alu_h_dat, lsu_h_dat;
    logic [SW-1:0]          alu_h_seq, lsu_h_seq, seq_diff;
    logic                   conflict, alu_older;

    assign alu_empty = (alu_wp_q == alu_rp_q);
    assign lsu_empty = (lsu_wp_q == lsu_rp_q);
    assign alu_full  = ((alu_wp_q ^ alu_rp_q) == FULL_DIFF);
    assign lsu_full  = ((lsu_wp_q ^ lsu_rp_q) == FULL_DIFF);

    assign alu_ready = !rst && !alu_full;
    assign lsu_ready = !rst && !lsu_full;
    assign alu_push  = alu_valid && alu_ready;
    assign lsu_push  = lsu_valid && lsu_ready;
    // Same-cycle accepts: ALU takes the older stamp
    assign lsu_stamp = seq_q + SW'(alu_push);

    assign alu_h_rd  = alu_rd_mem[alu_rp_q[AW-1:0]];
    assign alu_h_dat = alu_dat_mem[alu_rp_q[AW-1:0]];
    assign alu_h_seq = alu_seq_mem[alu_rp_q[AW-1:0]];
    assign lsu_h_rd  = lsu_rd_mem[lsu_rp_q[AW-1:0]];
    assign lsu_h_dat = lsu_dat_mem[lsu_rp_q[AW-1:0]];
    assign lsu_h_seq = lsu_seq_mem[lsu_rp_q[AW-1:0]];

    // ALU head is older when the modular distance to the LSU head is 1..7
    assign seq_diff  = lsu_h_seq - alu_h_seq;
    assign alu_older = (seq_diff != '0) && !seq_diff[SW-1];
    assign conflict  = !alu_empty && !lsu_empty && (alu_h_rd == lsu_h_rd)
                       && (alu_h_rd != '0);

    // Drain decision, pointer/stamp updates and next output register values
    always_comb begin
        alu_pop  = 1'b0;
        lsu_pop  = 1'b0;
        alu_wp_d = alu_wp_q;
        alu_rp_d = alu_rp_q;
        lsu_wp_d = lsu_wp_q;
        lsu_rp_d = lsu_rp_q;
        seq_d    = seq_q;
        vwe_d    = 2'b00;
        va5_d    = va5_q;
        va6_d    = va6_q;
        vwd1_d   = vwd1_q;
        vwd2_d   = vwd2_q;

        if (conflict) begin
            alu_pop = alu_older;
            lsu_pop = !alu_older;
        end else begin
            alu_pop = !alu_empty;
            lsu_pop = !lsu_empty;
        end

        alu_wp_d = alu_wp_q + PW'(alu_push);
        lsu_wp_d = lsu_wp_q + PW'(lsu_push);
        alu_rp_d = alu_rp_q + PW'(alu_pop);
        lsu_rp_d = lsu_rp_q + PW'(lsu_pop);
        seq_d    = seq_q + SW'(alu_push) + SW'(lsu_push);

        if (alu_pop) begin
            vwe_d[0] = (alu_h_rd != '0);
            va5_d    = alu_h_rd;
            vwd1_d   = alu_h_dat;
        end
        if (lsu_pop) begin
            vwe_d[1] = (lsu_h_rd != '0);
            va6_d    = lsu_h_rd;
            vwd2_d   = lsu_h_dat;
        end
    end

    // FIFO entry storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (alu_push) begin
            alu_rd_mem[alu_wp_q[AW-1:0]]  <= alu_rd;
            alu_dat_mem[alu_wp_q[AW-1:0]] <= alu_data;
            alu_seq_mem[alu_wp_q[AW-1:0]] <= seq_q;
        end
        if (lsu_push) begin
            lsu_rd_mem[lsu_wp_q[AW-1:0]]  <= lsu_rd;
            lsu_dat_mem[lsu_wp_q[AW-1:0]] <= lsu_data;
            lsu_seq_mem[lsu_wp_q[AW-1:0]] <= lsu_stamp;
        end
    end

    // Control and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_wp_q <= '0;
            alu_rp_q <= '0;
            lsu_wp_q <= '0;
            lsu_rp_q <= '0;
            seq_q    <= '0;
            vwe_q    <= 2'b00;
            va5_q    <= '0;
            va6_q    <= '0;
            vwd1_q   <= '0;
            vwd2_q   <= '0;
        end else begin
            alu_wp_q <= alu_wp_d;
            alu_rp_q <= alu_rp_d;
            lsu_wp_q <= lsu_wp_d;
            lsu_rp_q <= lsu_rp_d;
            seq_q    <= seq_d;
            vwe_q    <= vwe_d;
            va5_q    <= va5_d;
            va6_q    <= va6_d;
            vwd1_q   <= vwd1_d;
            vwd2_q   <= vwd2_d;
        end
    end

    assign vwe  = vwe_q;
    assign va5  = va5_q;
    assign va6  = va6_q;
    assign vwd1 = vwd1_q;
    assign vwd2 = vwd2_q;
    assign idle = alu_empty && lsu_empty && (vwe_q == 2'b00);

endmodule

// File: tb/tb_vec_wb_queue.sv
// Directed self-checking bench for vec_wb_queue; a negedge register-file model
// logs every committed write so ordering can be compared against acceptance order.
module tb_vec_wb_queue;

    localparam int unsigned XW = 128;
    localparam int unsigned RW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          alu_valid, alu_ready, lsu_valid, lsu_ready;
    logic [RW-1:0] alu_rd, lsu_rd, va5, va6;
    logic [XW-1:0] alu_data, lsu_data, vwd1, vwd2;
    logic [1:0]    vwe;
    logic          idle;

    int n_chk = 0;
    int n_err = 0;

    logic [RW-1:0] log_rd[$];
    logic [XW-1:0] log_dat[$];
    logic [XW-1:0] rf [32];

    vec_wb_queue #(.XLEN_VEC(XW), .RFIDX_WIDTH(RW), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .vwe(vwe), .va5(va5), .va6(va6), .vwd1(vwd1), .vwd2(vwd2), .idle(idle)
    );

    always #5 clk = ~clk;

    // Register file commits on the falling edge
    always @(negedge clk) begin
        if (vwe[0]) begin
            log_rd.push_back(va5);
            log_dat.push_back(vwd1);
            rf[va5] = vwd1;
        end
        if (vwe[1]) begin
            log_rd.push_back(va6);
            log_dat.push_back(vwd2);
            rf[va6] = vwd2;
        end
    end

    task automatic check(input string tag, input logic [XW-1:0] got, input logic [XW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (!idle && n < 50) begin
            step();
            n++;
        end
        check(tag, XW'(idle), XW'(1));
    endtask

    // Both streams push n beats to one rd whenever ready; writes must follow acceptance order
    task automatic run_stream(input int n, input logic [RW-1:0] rd, input logic [15:0] base,
                              input bit chk_rdy, input logic [9:0] exp_ar, input logic [9:0] exp_lr);
        int ai = 0;
        int li = 0;
        int cyc = 0;
        bit acc_a, acc_l;
        logic [XW-1:0] exp_q[$];
        log_rd.delete();
        log_dat.delete();
        while ((ai < n || li < n) && cyc < 200) begin
            alu_valid = (ai < n);
            alu_rd    = rd;
            alu_data  = {base, 16'h00A0, 96'(ai)};
            lsu_valid = (li < n);
            lsu_rd    = rd;
            lsu_data  = {base, 16'h00B0, 96'(li)};
            if (chk_rdy && cyc < 10) begin
                check($sformatf("alu_ready_c%0d", cyc), XW'(alu_ready), XW'(exp_ar[cyc]));
                check($sformatf("lsu_ready_c%0d", cyc), XW'(lsu_ready), XW'(exp_lr[cyc]));
            end
            acc_a = alu_valid && alu_ready;
            acc_l = lsu_valid && lsu_ready;
            step();
            if (acc_a) begin exp_q.push_back(alu_data); ai++; end
            if (acc_l) begin exp_q.push_back(lsu_data); li++; end
            cyc++;
        end
        alu_valid = 1'b0;
        lsu_valid = 1'b0;
        check("stream_accept_bound", XW'(cyc < 200), XW'(1));
        wait_idle("stream_idle");
        check("stream_wr_count", XW'(log_dat.size()), XW'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < log_dat.size(); i++) begin
            check($sformatf("stream_order_%0d", i), log_dat[i], exp_q[i]);
            check($sformatf("stream_rd_%0d", i), XW'(log_rd[i]), XW'(rd));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [XW-1:0] a0, a2, l1, dx, dy, d4;
        rst       = 1'b1;
        alu_valid = 1'b1;
        alu_rd    = 5'd3;
        alu_data  = {32{4'hA}} ^ 128'h5;
        lsu_valid = 1'b0;
        lsu_rd    = '0;
        lsu_data  = '0;
        for (int i = 0; i < 32; i++) rf[i] = '0;

        // Reset held with valid asserted
        step();
        step();
        check("rst_alu_ready", XW'(alu_ready), XW'(0));
        check("rst_lsu_ready", XW'(lsu_ready), XW'(0));
        check("rst_vwe", XW'(vwe), XW'(0));
        check("rst_idle", XW'(idle), XW'(1));
        check("rst_va5", XW'(va5), XW'(0));
        check("rst_vwd2", vwd2, XW'(0));

        // First beat after release: accepted, visible one cycle later
        rst = 1'b0;
        #1;
        check("post_rst_ready", XW'(alu_ready), XW'(1));
        step();
        alu_valid = 1'b0;
        check("first_lat_vwe0", XW'(vwe), XW'(0));
        step();
        check("first_vwe", XW'(vwe), XW'(2'b01));
        check("first_va5", XW'(va5), XW'(3));
        check("first_vwd1", vwd1, {32{4'hA}} ^ 128'h5);
        step();
        check("first_done_vwe", XW'(vwe), XW'(0));
        check("first_idle", XW'(idle), XW'(1));

        // Dual stream, different rd
        dx = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
        dy = 128'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0001;
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = dx;
        lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_data = dy;
        step();
        alu_valid = 1'b0;
        lsu_valid = 1'b0;
        check("dual_idle_busy", XW'(idle), XW'(0));
        step();
        check("dual_vwe", XW'(vwe), XW'(2'b11));
        check("dual_va5", XW'(va5), XW'(1));
        check("dual_va6", XW'(va6), XW'(2));
        check("dual_vwd1", vwd1, dx);
        check("dual_vwd2", vwd2, dy);
        step();
        check("dual_idle", XW'(idle), XW'(1));
        check("dual_hold_va6", XW'(va6), XW'(2));

        // WAW: A0/L1 together, then A2 one cycle after L1; order A0, L1, A2
        a0 = 128'hA0; l1 = 128'hB1; a2 = 128'hA2;
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = a0;
        lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = l1;
        step();
        lsu_valid = 1'b0;
        alu_data  = a2;
        step();
        alu_valid = 1'b0;
        check("waw_c1_vwe", XW'(vwe), XW'(2'b01));
        check("waw_c1_vwd1", vwd1, a0);
        step();
        check("waw_c2_vwe", XW'(vwe), XW'(2'b10));
        check("waw_c2_va6", XW'(va6), XW'(7));
        check("waw_c2_vwd2", vwd2, l1);
        step();
        check("waw_c3_vwe", XW'(vwe), XW'(2'b01));
        check("waw_c3_va5", XW'(va5), XW'(7));
        check("waw_c3_vwd1", vwd1, a2);
        step();
        check("waw_final_rf7", rf[7], a2);
        check("waw_idle", XW'(idle), XW'(1));

        // rd==0 consumed silently, following rd=4 beat writes one cycle later
        d4 = 128'h4444;
        log_rd.delete();
        log_dat.delete();
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 128'hDEAD;
        step();
        alu_rd = 5'd4; alu_data = d4;
        step();
        alu_valid = 1'b0;
        check("rd0_vwe", XW'(vwe), XW'(0));
        check("rd0_not_idle", XW'(idle), XW'(0));
        step();
        check("rd4_vwe", XW'(vwe), XW'(2'b01));
        check("rd4_va5", XW'(va5), XW'(4));
        check("rd4_vwd1", vwd1, d4);
        step();
        check("rd0_log_count", XW'(log_dat.size()), XW'(1));
        check("rd0_rf0", rf[0], XW'(0));
        check("rd0_idle", XW'(idle), XW'(1));

        // Backpressure: 8 beats per stream to rd=9, one conflicting pop per cycle
        run_stream(8, 5'd9, 16'hC0DE, 1'b1, 10'b0101111111, 10'b1010111111);

        // Stamp wrap: 20 beats per stream to rd=5 (40 total)
        run_stream(20, 5'd5, 16'h5EED, 1'b0, 10'b0, 10'b0);

        // Mid-stream reset drops in-flight entries
        log_rd.delete();
        log_dat.delete();
        alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 128'h10;
        lsu_valid = 1'b1; lsu_rd = 5'd11; lsu_data = 128'h11;
        step();
        alu_valid = 1'b0;
        lsu_valid = 1'b0;
        rst = 1'b1;
        step();
        check("midrst_vwe", XW'(vwe), XW'(0));
        check("midrst_idle", XW'(idle), XW'(1));
        check("midrst_ready", XW'(alu_ready), XW'(0));
        rst = 1'b0;
        step();
        step();
        check("midrst_no_writes", XW'(log_dat.size()), XW'(0));
        check("midrst_va5", XW'(va5), XW'(0));
        check("midrst_idle_after", XW'(idle), XW'(1));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
